register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_wr_gate.sv | 45 ++++
 rtl/register_file.sv | 64 ++++++
 tb/tb_register_file.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and its write gate.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wr_gate.sv
// Write qualification for the register file.
// Computes the effective write and the overflow trap, and holds the sticky exception state.
import regfile_pkg::*;

module regfile_wr_gate #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_overflow,
  input  logic              i_ovf_trap,
  input  logic              i_exc_clr,
  output logic              o_we_eff,
  output logic              o_ovf_exc,
  output logic [ADDR_W-1:0] o_exc_addr
);

  logic              r_ovf_exc;
  logic [ADDR_W-1:0] r_exc_addr;
  logic              w_trap;
  logic              w_ovf_hit;

  assign w_ovf_hit = i_overflow & i_ovf_trap;
  // Address 0 destinations still trap; only the data write is discarded for them.
  assign w_trap    = i_wr_en & w_ovf_hit & ~r_ovf_exc;
  assign o_we_eff  = i_wr_en & (i_wr_addr != ADDR_W'(0)) & ~w_ovf_hit & ~r_ovf_exc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf_exc  <= 1'b0;
      r_exc_addr <= '0;
    end else if (w_trap) begin
      r_ovf_exc  <= 1'b1;
      r_exc_addr <= i_wr_addr;
    end else if (i_exc_clr && r_ovf_exc) begin
      r_ovf_exc  <= 1'b0;
    end
  end

  assign o_ovf_exc  = r_ovf_exc;
  assign o_exc_addr = r_exc_addr;

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with overflow-trap write suppression.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
import regfile_pkg::*;

module register_file #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_overflow,
  input  logic              i_ovf_trap,
  input  logic              i_exc_clr,
  output logic              o_ovf_exc,
  output logic [ADDR_W-1:0] o_exc_addr
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_we_eff;

  regfile_wr_gate #(.ADDR_W(ADDR_W)) u_wr_gate (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_overflow (i_overflow),
    .i_ovf_trap (i_ovf_trap),
    .i_exc_clr  (i_exc_clr),
    .o_we_eff   (w_we_eff),
    .o_ovf_exc  (o_ovf_exc),
    .o_exc_addr (o_exc_addr)
  );

  // Entry 0 is held at zero so it can never carry data.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    always_ff @(posedge i_clk) begin
      if (i_rst || gi == 0) begin
        r_regs[gi] <= '0;
      end else if (w_we_eff && i_wr_addr == ADDR_W'(gi)) begin
        r_regs[gi] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_data1 = (i_rd_addr1 == ADDR_W'(0)) ? '0 : r_regs[i_rd_addr1];
    o_rd_data2 = (i_rd_addr2 == ADDR_W'(0)) ? '0 : r_regs[i_rd_addr2];
`ifdef REGFILE_BYPASS_EN
    // w_we_eff already implies a nonzero destination.
    if (w_we_eff && i_rd_addr1 == i_wr_addr) o_rd_data1 = i_wr_data;
    if (w_we_eff && i_rd_addr2 == i_wr_addr) o_rd_data2 = i_wr_data;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios then randomized traffic vs. a reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr, exc_addr;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        wr_en, overflow, ovf_trap, exc_clr, ovf_exc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  // Reference model state
  logic [31:0] ref_regs [32];
  logic        ref_exc;
  logic [4:0]  ref_exc_addr;

  register_file dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_addr1 (rd_addr1),
    .i_rd_addr2 (rd_addr2),
    .o_rd_data1 (rd_data1),
    .o_rd_data2 (rd_data2),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_overflow (overflow),
    .i_ovf_trap (ovf_trap),
    .i_exc_clr  (exc_clr),
    .o_ovf_exc  (ovf_exc),
    .o_exc_addr (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic wr_now,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_now && a == wa) return wd;
`endif
    return ref_regs[a];
  endfunction

  // One clock transaction: drive, check reads before the edge, update model, check state after.
  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ovf, input logic trp, input logic clr,
                      input logic [4:0] a1, input logic [4:0] a2);
    logic wr_now;
    logic trap_now;
    logic old_exc;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    overflow = ovf; ovf_trap = trp; exc_clr = clr;
    rd_addr1 = a1; rd_addr2 = a2;
    #2;
    old_exc  = ref_exc;
    trap_now = we && ovf && trp && !old_exc;
    wr_now   = we && (wa != 5'd0) && !(ovf && trp) && !old_exc;
    check_val("rd_data1", rd_data1, ref_read(a1, wr_now, wa, wd));
    check_val("rd_data2", rd_data2, ref_read(a2, wr_now, wa, wd));
    if (r) begin
      foreach (ref_regs[i]) ref_regs[i] = 32'h0;
      ref_exc = 1'b0;
      ref_exc_addr = 5'd0;
    end else if (trap_now) begin
      ref_exc = 1'b1;
      ref_exc_addr = wa;
    end else begin
      if (wr_now) ref_regs[wa] = wd;
      if (old_exc && clr) ref_exc = 1'b0;
    end
    @(posedge clk);
    #1;
    check_val("ovf_exc", {31'h0, ovf_exc}, {31'h0, ref_exc});
    check_val("exc_addr", {27'h0, exc_addr}, {27'h0, ref_exc_addr});
    n_txn++;
    $display("[TB] txn %0d rst=%0b we=%0b wa=%0d wd=%08h ovf=%0b trap=%0b clr=%0b a1=%0d a2=%0d exc=%0b", n_txn, r, we, wa, wd, ovf, trp, clr, a1, a2, ovf_exc);
    @(negedge clk);
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, a1, a2);
  endtask

  initial begin
    foreach (ref_regs[i]) ref_regs[i] = 32'h0;
    ref_exc = 1'b0; ref_exc_addr = 5'd0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    overflow = 1'b0; ovf_trap = 1'b0; exc_clr = 1'b0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    @(negedge clk);
    // Reset first; the model starts cleared so unknowns before reset are only read at address 0.
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

    // Write/read and register 0
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2);
    idle_read(5'd5, 5'd5);
    check_val("r5_direct", rd_data1, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5);
    idle_read(5'd0, 5'd0);

    // Trap, blocked write, clear with blocked write, then successful write
    step(1'b0, 1'b1, 5'd8, 32'h00000011, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9);
    step(1'b0, 1'b1, 5'd8, 32'h80000000, 1'b1, 1'b1, 1'b0, 5'd8, 5'd8);
    check_val("trap_exc", {31'h0, ovf_exc}, 32'h1);
    check_val("trap_addr", {27'h0, exc_addr}, 32'd8);
    step(1'b0, 1'b1, 5'd9, 32'h7, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9);
    step(1'b0, 1'b1, 5'd9, 32'h7, 1'b0, 1'b0, 1'b1, 5'd8, 5'd9);
    check_val("clr_exc", {31'h0, ovf_exc}, 32'h0);
    check_val("clr_addr_hold", {27'h0, exc_addr}, 32'd8);
    idle_read(5'd9, 5'd8);
    check_val("r8_kept", rd_data2, 32'h11);
    step(1'b0, 1'b1, 5'd9, 32'h7, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9);
    idle_read(5'd9, 5'd0);
    check_val("r9_after_clr", rd_data1, 32'h7);

    // Trap to address 0, clear with no exception pending plus trap same cycle
    step(1'b0, 1'b1, 5'd0, 32'h5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2);
    step(1'b0, 1'b1, 5'd12, 32'h5, 1'b1, 1'b1, 1'b1, 5'd12, 5'd0);
    check_val("trap_with_clr", {31'h0, ovf_exc}, 32'h1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd12, 5'd3);

    // Non-trapping overflow and same-cycle read of the written register
    step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
    idle_read(5'd3, 5'd3);
    check_val("r3_addu", rd_data1, 32'h1);
    step(1'b0, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4);

    // Randomized traffic with occasional reset, trap and clear
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 5'($urandom),
           $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, 5'($urandom), 5'($urandom));
    end

    // Arbitrary writes, reset, then sweep all 32 addresses
    if (ref_exc) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0);
    for (int n = 1; n < 32; n++)
      step(1'b0, 1'b1, 5'(n), $urandom, 1'b0, 1'b0, 1'b0, 5'(n), 5'(n - 1));
    step(1'b1, 1'b1, 5'd7, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd7, 5'd6);
    for (int n = 0; n < 32; n += 2) begin
      idle_read(5'(n), 5'(n + 1));
      check_val("rst_sweep1", rd_data1, 32'h0);
      check_val("rst_sweep2", rd_data2, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
